// File: rtl/mul_sched_pkg.sv
// Shared defaults and types for the multiplier-tree scheduler.
package mul_sched_pkg;

  localparam int NREQ_DEF       = 4;
  localparam int W_DEF          = 8;
  localparam int LAT_DEF        = 6;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int ID_W           = (NREQ_DEF > 1) ? $clog2(NREQ_DEF) : 1;

  // One slot of the tag pipeline that rides alongside the tree.
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  // One response FIFO entry.
  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [2*W_DEF-1:0] data;
  } rsp_entry_t;

  // Round-robin successor of a requester index, wrapping at nreq.
  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] idx, input int nreq);
    rr_next = (int'(idx) == nreq - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/mul_tree_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr_i.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  input  logic            enable_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o
);

  logic          found;
  logic [IW-1:0] pos;

  // Scan ptr, ptr+1, ... (mod NREQ) and take the first active request.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    pos     = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = IW'((int'(ptr_i) + k) % NREQ);
      if (enable_i && !found && req_i[pos]) begin
        grant_o[pos] = 1'b1;
        idx_o        = pos;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_tree_scheduler.sv
// Shares one fixed-latency multiplier tree among NREQ requesters.
// Handshakes: a transfer happens in a cycle where valid & ready are both
// high. req_ready depends combinationally on req_valid, so requesters must
// never derive req_valid from req_ready. The response side pops on
// rsp_valid & rsp_ready. Credits bound in-flight + buffered results to
// FIFO_DEPTH so the non-stallable tree can never overflow the FIFO.
module mul_tree_scheduler
  import mul_sched_pkg::*;
#(
  parameter int NREQ       = NREQ_DEF,
  parameter int W          = W_DEF,
  parameter int LAT        = LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              mul_valid,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic [2*W-1:0]    mul_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [2*W-1:0]    rsp_data,
  output logic              busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [NREQ-1:0] grant;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [CW-1:0]   credits_q, credits_d;
  logic            issue_allowed, handshake, pop, push;
  logic [W-1:0]    sel_a, sel_b;

  logic            mul_valid_q;
  logic [W-1:0]    mul_a_q, mul_b_q;
  logic [ID_W-1:0] mul_id_q;

  tag_t            tag_q [LAT];

  rsp_entry_t      fifo_mem [FIFO_DEPTH];
  rsp_entry_t      head;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  assign rsp_valid     = (count_q != '0);
  assign pop           = rsp_valid & rsp_ready;
  // A pop in the same cycle frees a credit, so a full scheduler can still issue.
  assign issue_allowed = (credits_q < CW'(FIFO_DEPTH)) | pop;
  assign handshake     = |grant;
  assign req_ready     = grant;
  assign push          = tag_q[LAT-1].valid;

  rr_arbiter #(.NREQ(NREQ), .IW(ID_W)) u_arb (
    .req_i    (req_valid),
    .ptr_i    (ptr_q),
    .enable_i (issue_allowed),
    .grant_o  (grant),
    .idx_o    (grant_idx)
  );

  // Select the granted requester's operands.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
    end
  end

  // Next-state for priority pointer, credits and FIFO bookkeeping.
  always_comb begin
    ptr_d     = handshake ? rr_next(grant_idx, NREQ) : ptr_q;
    credits_d = credits_q;
    if (handshake && !pop)      credits_d = credits_q + 1'b1;
    else if (!handshake && pop) credits_d = credits_q - 1'b1;
    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_d = rd_ptr_q;
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      credits_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      ptr_q     <= ptr_d;
      credits_q <= credits_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Registered issue into the tree; operands hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_id_q    <= '0;
    end else begin
      mul_valid_q <= handshake;
      if (handshake) begin
        mul_a_q  <= sel_a;
        mul_b_q  <= sel_b;
        mul_id_q <= grant_idx;
      end
    end
  end

  // Tag pipeline: tail valid marks the cycle mul_result belongs to us.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0].valid <= mul_valid_q;
      tag_q[0].id    <= mul_id_q;
      for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Response storage; no reset needed since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q].id   <= tag_q[LAT-1].id;
      fifo_mem[wr_ptr_q].data <= mul_result;
    end
  end

  assign head      = fifo_mem[rd_ptr_q];
  assign rsp_id    = rsp_valid ? head.id : '0;
  assign rsp_data  = rsp_valid ? head.data : '0;
  assign mul_valid = mul_valid_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign busy      = (credits_q != '0);

endmodule

// File: tb/tb_mul_tree_scheduler.sv
// Self-checking bench for mul_tree_scheduler with an attached tree model.
module tb_mul_tree_scheduler;

  localparam int NREQ       = 4;
  localparam int W          = 8;
  localparam int LAT        = 6;
  localparam int FIFO_DEPTH = 8;
  localparam int ID_W       = 2;
  localparam int RW         = ID_W + 2*W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic              mul_valid;
  logic [W-1:0]      mul_a, mul_b;
  logic [2*W-1:0]    mul_result;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [ID_W-1:0]   rsp_id;
  logic [2*W-1:0]    rsp_data;
  logic              busy;

  mul_tree_scheduler #(.NREQ(NREQ), .W(W), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .mul_valid  (mul_valid),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  // ---------------- tree model: product LAT cycles after mul_valid ----------------
  logic [2*W-1:0] tree_pipe [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) tree_pipe[i] <= tree_pipe[i-1];
    tree_pipe[0] <= mul_valid ? ((2*W)'(mul_a) * (2*W)'(mul_b)) : (2*W)'($urandom);
  end
  assign mul_result = tree_pipe[LAT-1];

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [RW-1:0]   exp_q[$];
  int              exp_t[$];
  int              m_ptr = 0;
  int              m_credits = 0;
  logic            m_mul_valid = 1'b0;
  logic [W-1:0]    m_mul_a = '0, m_mul_b = '0;
  logic            m_rsp_valid, m_pop;
  logic [NREQ-1:0] exp_grant;
  int              g_idx;
  logic [RW-1:0]   head;
  int              dut_hs [NREQ];
  int              dut_pops = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_t.delete();
      m_ptr       = 0;
      m_credits   = 0;
      m_mul_valid = 1'b0;
      m_mul_a     = '0;
      m_mul_b     = '0;
    end else begin
      m_rsp_valid = (exp_q.size() > 0) && (exp_t[0] <= cyc);
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
      if (m_rsp_valid) begin
        head = exp_q[0];
        chk("rsp_id", 32'(rsp_id), 32'(head[RW-1 -: ID_W]));
        chk("rsp_data", 32'(rsp_data), 32'(head[2*W-1:0]));
      end
      m_pop = m_rsp_valid && rsp_ready;
      exp_grant = '0;
      g_idx = -1;
      if (m_credits < FIFO_DEPTH || m_pop)
        for (int k = 0; k < NREQ; k++)
          if (g_idx < 0 && req_valid[(m_ptr + k) % NREQ]) g_idx = (m_ptr + k) % NREQ;
      if (g_idx >= 0) exp_grant[g_idx] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_grant));
      chk("mul_valid", 32'(mul_valid), 32'(m_mul_valid));
      chk("mul_a", 32'(mul_a), 32'(m_mul_a));
      chk("mul_b", 32'(mul_b), 32'(m_mul_b));
      chk("busy", 32'(busy), 32'(m_credits != 0));
      for (int k = 0; k < NREQ; k++) if (req_valid[k] && req_ready[k]) dut_hs[k]++;
      if (rsp_valid && rsp_ready) dut_pops++;
      if (m_pop) begin
        void'(exp_q.pop_front());
        void'(exp_t.pop_front());
      end
      m_mul_valid = (g_idx >= 0);
      if (g_idx >= 0) begin
        m_mul_a = req_a[g_idx*W +: W];
        m_mul_b = req_b[g_idx*W +: W];
        exp_q.push_back({ID_W'(g_idx), (2*W)'(m_mul_a) * (2*W)'(m_mul_b)});
        exp_t.push_back(cyc + LAT + 2);
        m_ptr = (g_idx + 1) % NREQ;
      end
      m_credits = m_credits + ((g_idx >= 0) ? 1 : 0) - (m_pop ? 1 : 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    step();
    rst = 1'b1;
    req_valid = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic check_reset_values();
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_mul_valid", 32'(mul_valid), 32'(0));
    chk("rst_mul_a", 32'(mul_a), 32'(0));
    chk("rst_mul_b", 32'(mul_b), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_id", 32'(rsp_id), 32'(0));
    chk("rst_rsp_data", 32'(rsp_data), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
  endtask

  // One isolated request; checks latency, id, product and busy falling.
  task automatic single_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2*W-1:0] exp_data, output int wt);
    int  hs;
    bit  got;
    step();
    rsp_ready = 1'b1;
    req_valid[id] = 1'b1;
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    wt = 0;
    hs = 0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        got = 1'b1;
        hs = cyc;
      end else wt++;
    end
    chk("single_hs_seen", 32'(got), 32'(1));
    step();
    req_valid[id] = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        chk("single_latency", 32'(cyc - hs), 32'(LAT + 2));
        chk("single_id", 32'(rsp_id), 32'(id));
        chk("single_data", 32'(rsp_data), 32'(exp_data));
      end
    end
    chk("single_rsp_seen", 32'(got), 32'(1));
    @(negedge clk);
    chk("single_busy_after_pop", 32'(busy), 32'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int wt, base, basep;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_values();

    // Single request and product corners
    single_req(0, 8'h0F, 8'h11, 16'h00FF, wt);
    single_req(0, 8'hFF, 8'hFF, 16'hFE01, wt);
    single_req(1, 8'h00, 8'hA5, 16'h0000, wt);

    // All requesters continuously valid: strict rotation, one per cycle
    pulse_reset();
    rsp_ready = 1'b1;
    basep = dut_pops;
    for (int k = 0; k < 16; k++) begin
      req_valid = '1;
      req_a = $urandom;
      req_b = $urandom;
      @(negedge clk);
      chk("rr_grant", 32'(req_ready), 32'(1) << (k % NREQ));
      step();
    end
    req_valid = '0;
    repeat (LAT + 4) step();
    chk("rr_pops", 32'(dut_pops - basep), 32'(16));

    // Backpressure: only FIFO_DEPTH issues, then blocked
    pulse_reset();
    rsp_ready = 1'b0;
    base = dut_hs[1];
    for (int k = 0; k < 20; k++) begin
      req_valid = 4'b0010;
      req_a = $urandom;
      req_b = $urandom;
      step();
    end
    @(negedge clk);
    chk("bp_blocked", 32'(req_ready), 32'(0));
    chk("bp_hs_count", 32'(dut_hs[1] - base), 32'(FIFO_DEPTH));

    // Full credits with simultaneous pop and issue
    step();
    base = dut_hs[2];
    basep = dut_pops;
    rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      req_valid = 4'b0100;
      req_a = $urandom;
      req_b = $urandom;
      @(negedge clk);
      chk("full_grant", 32'(req_ready), 32'(4'b0100));
      chk("full_busy", 32'(busy), 32'(1));
      step();
    end
    req_valid = '0;
    repeat (20) step();
    chk("full_hs_count", 32'(dut_hs[2] - base), 32'(10));
    chk("bp_pops", 32'(dut_pops - basep), 32'(18));
    @(negedge clk);
    chk("bp_drained_valid", 32'(rsp_valid), 32'(0));
    chk("bp_drained_busy", 32'(busy), 32'(0));

    // Reset mid-flight
    pulse_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid = 4'b0001;
      req_a = $urandom;
      req_b = $urandom;
      step();
    end
    pulse_reset();
    check_reset_values();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("stale_rsp_valid", 32'(rsp_valid), 32'(0));
    end
    single_req(3, 8'h03, 8'h05, 16'h000F, wt);
    chk("req3_immediate", 32'(wt), 32'(0));
    step();
    req_valid = 4'b1001;
    @(negedge clk);
    chk("ptr_wrapped", 32'(req_ready), 32'(4'b0001));
    step();
    req_valid = '0;
    repeat (12) step();

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      req_valid = NREQ'($urandom);
      req_a = $urandom;
      req_b = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (FIFO_DEPTH + LAT + 6) step();
    @(negedge clk);
    chk("rand_drained_valid", 32'(rsp_valid), 32'(0));
    chk("rand_drained_busy", 32'(busy), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // ---------------- run limit ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: run limit reached at cycle %0d", cyc);
    $fatal(1, "run limit");
  end

endmodule
